// File: rtl/pre.sv
// ---------------------------------------------------------------------------
// pre : transmit-side framer toward the RTDS Aurora TX.
//
// Accepts AXI-Stream frames from upstream and, when ctrl_seq_en is set at the
// start of a frame, appends a trailing 32-bit sequence-number word after the
// frame's last data beat. A single output register carries every beat, so the
// block is a one-stage pipeline with full valid/ready handshaking both sides.
// The word count of each transmitted frame is reported with a one-cycle pulse.
//
// Ports
//   m_axis_aclk        sole clock, rising edge
//   m_axis_areset      synchronous active-high reset
//   s_axis_tvalid/tready/tdata/tlast  upstream AXI-Stream slave (32-bit)
//   m_axis_tvalid/tready/tdata/tlast  downstream AXI-Stream master (32-bit)
//   ctrl_seq_en        1 = append sequence word to the next frame
//   stat_cnt_pkts      word count of the last completed output frame
//   stat_cnt_pkts_rdy  one-cycle pulse when stat_cnt_pkts updates
//   stat_seq           value the next appended sequence word will carry
// ---------------------------------------------------------------------------
module pre #(
  parameter logic [31:0] SEQ_INIT = 32'h0000_0000
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        ctrl_seq_en,
  output logic [15:0] stat_cnt_pkts,
  output logic        stat_cnt_pkts_rdy,
  output logic [31:0] stat_seq
);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  state_t      state;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] seq_cnt;
  logic [15:0] cnt_words;
  logic [15:0] cnt_pkts;
  logic        pkts_rdy;
  logic        in_frame;
  logic        en_lat;

  logic        reg_free;
  logic        s_accept;
  logic        m_hs;
  logic        frame_en;

  // The output register may take a new beat when it is empty or draining now.
  assign reg_free = ~out_valid | m_axis_tready;

  // Reset gating keeps tready low while reset is held, independent of the
  // register contents left over from before reset.
  assign s_axis_tready = (state == ST_DATA) & reg_free & ~m_axis_areset;
  assign s_accept      = s_axis_tvalid & s_axis_tready;
  assign m_hs          = out_valid & m_axis_tready;

  // On the first beat of a frame the live enable is used; afterwards the
  // value captured on that first beat, so mid-frame toggles wait a frame.
  assign frame_en = in_frame ? en_lat : ctrl_seq_en;

  assign m_axis_tvalid     = out_valid;
  assign m_axis_tdata      = out_data;
  assign m_axis_tlast      = out_last;
  assign stat_cnt_pkts     = cnt_pkts;
  assign stat_cnt_pkts_rdy = pkts_rdy;
  assign stat_seq          = seq_cnt;

  // Framing FSM and output register.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state     <= ST_DATA;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_last  <= 1'b0;
      seq_cnt   <= SEQ_INIT;
      in_frame  <= 1'b0;
      en_lat    <= 1'b0;
    end else begin
      case (state)
        ST_DATA: begin
          if (s_accept) begin
            out_valid <= 1'b1;
            out_data  <= s_axis_tdata;
            in_frame  <= ~s_axis_tlast;
            en_lat    <= frame_en;
            // The sequence word, not the data beat, closes an enabled frame.
            if (s_axis_tlast && frame_en) begin
              out_last <= 1'b0;
              state    <= ST_SEQ;
            end else begin
              out_last <= s_axis_tlast;
            end
          end else if (m_hs) begin
            out_valid <= 1'b0;
          end
        end
        ST_SEQ: begin
          if (reg_free) begin
            out_valid <= 1'b1;
            out_data  <= seq_cnt;
            out_last  <= 1'b1;
            seq_cnt   <= seq_cnt + 32'd1;
            state     <= ST_DATA;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

  // Output word counter; saturates so an oversize frame reports FFFF.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      cnt_words <= 16'h0;
      cnt_pkts  <= 16'h0;
      pkts_rdy  <= 1'b0;
    end else begin
      pkts_rdy <= 1'b0;
      if (m_hs) begin
        if (out_last) begin
          cnt_pkts  <= (cnt_words == 16'hFFFF) ? 16'hFFFF : cnt_words + 16'd1;
          cnt_words <= 16'h0;
          pkts_rdy  <= 1'b1;
        end else if (cnt_words != 16'hFFFF) begin
          cnt_words <= cnt_words + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pre.sv
// ---------------------------------------------------------------------------
// tb_pre : directed self-checking bench for pre.
// A second instance built with SEQ_INIT = FFFF_FFFF shares all inputs and is
// observed for the sequence wrap-around case.
// ---------------------------------------------------------------------------
module tb_pre;

  logic        clk = 1'b0;
  logic        areset;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tready;
  logic        seq_en;

  logic        s_tready,  s_tready2;
  logic        m_tvalid,  m_tvalid2;
  logic [31:0] m_tdata,   m_tdata2;
  logic        m_tlast,   m_tlast2;
  logic [15:0] stat_pkts, stat_pkts2;
  logic        stat_rdy,  stat_rdy2;
  logic [31:0] stat_seq,  stat_seq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pre dut (
    .m_axis_aclk       (clk),
    .m_axis_areset     (areset),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tdata      (s_tdata),
    .s_axis_tlast      (s_tlast),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tlast      (m_tlast),
    .ctrl_seq_en       (seq_en),
    .stat_cnt_pkts     (stat_pkts),
    .stat_cnt_pkts_rdy (stat_rdy),
    .stat_seq          (stat_seq)
  );

  pre #(.SEQ_INIT(32'hFFFF_FFFF)) dut2 (
    .m_axis_aclk       (clk),
    .m_axis_areset     (areset),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready2),
    .s_axis_tdata      (s_tdata),
    .s_axis_tlast      (s_tlast),
    .m_axis_tvalid     (m_tvalid2),
    .m_axis_tready     (m_tready),
    .m_axis_tdata      (m_tdata2),
    .m_axis_tlast      (m_tlast2),
    .ctrl_seq_en       (seq_en),
    .stat_cnt_pkts     (stat_pkts2),
    .stat_cnt_pkts_rdy (stat_rdy2),
    .stat_seq          (stat_seq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    areset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    areset = 1'b0;
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [31:0] held_data;
    logic        held_last;
    logic        prev_stall;
    logic        acc;
    int          idx;
    int          ox;

    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    seq_en   = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    checkOutput("rst_s_tready", 32'(s_tready), 32'h0);
    checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    checkOutput("rst_m_tdata", m_tdata, 32'h0);
    checkOutput("rst_m_tlast", 32'(m_tlast), 32'h0);
    checkOutput("rst_stat_pkts", 32'(stat_pkts), 32'h0);
    checkOutput("rst_stat_rdy", 32'(stat_rdy), 32'h0);
    checkOutput("rst_stat_seq", stat_seq, 32'h0);
    checkOutput("rst_stat_seq2", stat_seq2, 32'hFFFF_FFFF);
    areset = 1'b0;
    #1;
    checkOutput("post_rst_s_tready", 32'(s_tready), 32'h1);

    // ---------------- 4-word frame with sequence word ----------------
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), (i == 3));
      checkOutput("t1_s_tready", 32'(s_tready), 32'h1);
      tick();
      checkOutput("t1_data", m_tdata, 32'hA0 + 32'(i));
      checkOutput("t1_last", 32'(m_tlast), 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_s_tready_seq", 32'(s_tready), 32'h0);
    tick();
    checkOutput("t1_seq_valid", 32'(m_tvalid), 32'h1);
    checkOutput("t1_seq_data", m_tdata, 32'h0);
    checkOutput("t1_seq_last", 32'(m_tlast), 32'h1);
    checkOutput("t1_stat_seq", stat_seq, 32'h1);
    checkOutput("t1_rdy_early", 32'(stat_rdy), 32'h0);
    tick();
    checkOutput("t1_stat_pkts", 32'(stat_pkts), 32'd5);
    checkOutput("t1_rdy", 32'(stat_rdy), 32'h1);
    checkOutput("t1_idle", 32'(m_tvalid), 32'h0);
    tick();
    checkOutput("t1_rdy_pulse_end", 32'(stat_rdy), 32'h0);

    // ---------------- three back-to-back 2-word frames ----------------
    applyReset();
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 32'hB000_0000 + 32'(f * 16), 1'b0);
      checkOutput("t2_s_tready_b0", 32'(s_tready), 32'h1);
      tick();
      checkOutput("t2_data0", m_tdata, 32'hB000_0000 + 32'(f * 16));
      if (f > 0) begin
        checkOutput("t2_stat_pkts", 32'(stat_pkts), 32'd3);
        checkOutput("t2_rdy", 32'(stat_rdy), 32'h1);
      end
      applyStimulus(1'b1, 32'hB000_0001 + 32'(f * 16), 1'b1);
      tick();
      checkOutput("t2_data1", m_tdata, 32'hB000_0001 + 32'(f * 16));
      checkOutput("t2_last1", 32'(m_tlast), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("t2_s_tready_low", 32'(s_tready), 32'h0);
      tick();
      checkOutput("t2_seq_data", m_tdata, 32'(f));
      checkOutput("t2_seq_last", 32'(m_tlast), 32'h1);
      checkOutput("t2_s_tready_back", 32'(s_tready), 32'h1);
    end
    tick();
    checkOutput("t2_stat_pkts_last", 32'(stat_pkts), 32'd3);
    checkOutput("t2_rdy_last", 32'(stat_rdy), 32'h1);
    checkOutput("t2_stat_seq", stat_seq, 32'd3);

    // ---------------- pass-through 3-word frame ----------------
    seq_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hC0 + 32'(i), (i == 2));
      checkOutput("t3_s_tready", 32'(s_tready), 32'h1);
      tick();
      checkOutput("t3_data", m_tdata, 32'hC0 + 32'(i));
      checkOutput("t3_last", 32'(m_tlast), (i == 2) ? 32'h1 : 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3_s_tready_after", 32'(s_tready), 32'h1);
    tick();
    checkOutput("t3_stat_pkts", 32'(stat_pkts), 32'd3);
    checkOutput("t3_rdy", 32'(stat_rdy), 32'h1);
    checkOutput("t3_idle", 32'(m_tvalid), 32'h0);
    checkOutput("t3_stat_seq", stat_seq, 32'd3);

    // ---------------- 16-word frame under backpressure ----------------
    applyReset();
    seq_en     = 1'b1;
    pat        = 16'hB269;
    idx        = 0;
    ox         = 0;
    prev_stall = 1'b0;
    held_data  = 32'h0;
    held_last  = 1'b0;
    for (int cyc = 0; cyc < 200 && ox < 17; cyc++) begin
      m_tready = pat[cyc % 16];
      if (idx < 16) applyStimulus(1'b1, 32'hE000_0000 + 32'(idx), (idx == 15));
      else          applyStimulus(1'b0, 32'h0, 1'b0);
      if (prev_stall) begin
        checkOutput("bp_hold_valid", 32'(m_tvalid), 32'h1);
        checkOutput("bp_hold_data", m_tdata, held_data);
        checkOutput("bp_hold_last", 32'(m_tlast), 32'(held_last));
      end
      acc = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        checkOutput("bp_data", m_tdata, (ox < 16) ? 32'hE000_0000 + 32'(ox) : 32'h0);
        checkOutput("bp_last", 32'(m_tlast), (ox == 16) ? 32'h1 : 32'h0);
        ox++;
      end
      prev_stall = m_tvalid & ~m_tready;
      held_data  = m_tdata;
      held_last  = m_tlast;
      tick();
      if (acc) idx++;
    end
    checkOutput("bp_word_count", 32'(ox), 32'd17);
    checkOutput("bp_stat_pkts", 32'(stat_pkts), 32'd17);
    checkOutput("bp_rdy", 32'(stat_rdy), 32'h1);
    m_tready = 1'b1;

    // ---------------- sequence wrap on SEQ_INIT = FFFF_FFFF ----------------
    applyReset();
    applyStimulus(1'b1, 32'h0000_00D0, 1'b1);
    tick();
    checkOutput("wrap_data0", m_tdata2, 32'h0000_00D0);
    checkOutput("wrap_last0", 32'(m_tlast2), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_seq0", m_tdata2, 32'hFFFF_FFFF);
    checkOutput("wrap_seq0_last", 32'(m_tlast2), 32'h1);
    applyStimulus(1'b1, 32'h0000_00D1, 1'b1);
    tick();
    checkOutput("wrap_stat0", 32'(stat_pkts2), 32'd2);
    checkOutput("wrap_rdy0", 32'(stat_rdy2), 32'h1);
    checkOutput("wrap_data1", m_tdata2, 32'h0000_00D1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_seq1", m_tdata2, 32'h0000_0000);
    checkOutput("wrap_seq1_last", 32'(m_tlast2), 32'h1);
    checkOutput("wrap_stat_seq", stat_seq2, 32'h1);
    tick();
    checkOutput("wrap_stat1", 32'(stat_pkts2), 32'd2);
    checkOutput("wrap_rdy1", 32'(stat_rdy2), 32'h1);

    // ---------------- mid-frame enable toggle, then mid-frame reset ----------------
    seq_en = 1'b1;
    applyStimulus(1'b1, 32'h0000_0F00, 1'b0);
    tick();
    seq_en = 1'b0;
    applyStimulus(1'b1, 32'h0000_0F01, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0F02, 1'b1);
    tick();
    checkOutput("tog_data2", m_tdata, 32'h0000_0F02);
    checkOutput("tog_last2", 32'(m_tlast), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("tog_s_tready", 32'(s_tready), 32'h0);
    tick();
    checkOutput("tog_seq_data", m_tdata, 32'd2);
    checkOutput("tog_seq_last", 32'(m_tlast), 32'h1);
    tick();
    checkOutput("tog_stat_pkts", 32'(stat_pkts), 32'd4);

    seq_en = 1'b1;
    applyStimulus(1'b1, 32'h0000_0A00, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0A01, 1'b0);
    tick();
    checkOutput("mid_data", m_tdata, 32'h0000_0A01);
    areset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("mid_rst_s_tready", 32'(s_tready), 32'h0);
    checkOutput("mid_rst_valid", 32'(m_tvalid), 32'h0);
    checkOutput("mid_rst_data", m_tdata, 32'h0);
    checkOutput("mid_rst_last", 32'(m_tlast), 32'h0);
    checkOutput("mid_rst_stat_pkts", 32'(stat_pkts), 32'h0);
    checkOutput("mid_rst_stat_seq", stat_seq, 32'h0);
    checkOutput("mid_rst_stat_seq2", stat_seq2, 32'hFFFF_FFFF);
    areset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_no_seq_word", 32'(m_tvalid), 32'h0);
    end
    seq_en = 1'b0;
    applyStimulus(1'b1, 32'h0000_0B00, 1'b1);
    tick();
    checkOutput("post_rst_data", m_tdata, 32'h0000_0B00);
    checkOutput("post_rst_last", 32'(m_tlast), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("post_rst_stat_pkts", 32'(stat_pkts), 32'd1);
    checkOutput("post_rst_stat_seq", stat_seq, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
